pulse_channel: RTL and testbench
================================

PULSE_CHANNEL -- requirements
Module: pulse_channel

Interface
REQ-001 Parameter PHASE_W, default 32, phase accumulator width (>=4).
REQ-002 Parameter AMP_W, default 8, output sample width (>=5).
REQ-003 Parameter LEN_W, default 8, length counter width.
REQ-004 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-high.
REQ-006 step_in  input  1  sample-rate strobe; one phase step per high cycle.
REQ-007 phase_incr_in  input  PHASE_W  unsigned phase increment per step.
REQ-008 duty_in  input  2  duty select: 0=12.5%, 1=25%, 2=50%, 3=75%.
REQ-009 volume_in  input  4  unsigned volume 0..15.
REQ-010 trigger_in  input  1  single-cycle note start.
REQ-011 length_in  input  LEN_W  note length in waveform periods, sampled on trigger.
REQ-012 length_halt_in  input  1  high = length counter frozen (infinite note).
REQ-013 env_period_in  input  4  envelope decay period in waveform periods; 0 = no decay.
REQ-014 amp_out  output  AMP_W  signed two's-complement sample.
REQ-015 active_out  output  1  high while the channel is in PLAY.

Function
REQ-016 Two states, IDLE and PLAY; active_out SHALL equal (state==PLAY).
REQ-017 trigger_in SHALL, in any state, clear phase to 0 and load the length counter from length_in; next state PLAY, except length_in==0 with length_halt_in low -> IDLE.
REQ-018 In PLAY, each step_in without trigger_in SHALL add phase_incr_in to phase modulo 2^PHASE_W; in IDLE phase SHALL hold.
REQ-019 A wrap event SHALL be a step whose addition carries out of bit PHASE_W-1.
REQ-020 On a wrap with length_halt_in low, the length counter SHALL decrement; a decrement from 1 to 0 SHALL move the state to IDLE on the same edge.
REQ-021 trigger_in and step_in in the same cycle: trigger wins; no phase add, no decrement, no wrap.
REQ-022 Let t = phase[PHASE_W-1:PHASE_W-3]; high level when t<1, t<2, t<4, t<6 for duty 0,1,2,3 respectively.
REQ-023 amp_out SHALL be registered, reflecting phase/state/volume of the previous cycle (one-cycle latency).
REQ-024 In PLAY amp_out SHALL be +(vol_eff<<(AMP_W-5)) when high, -(vol_eff<<(AMP_W-5)) when low; in IDLE amp_out SHALL be 0.
REQ-025 duty_in, volume_in, phase_incr_in changes SHALL take effect without retrigger and without phase disturbance.

Reset
REQ-026 rst_in SHALL force state IDLE, phase 0, length counter 0, envelope level 0, envelope divider 0, amp_out 0, active_out 0, overriding trigger_in and step_in.
REQ-027 rst_in mid-note SHALL silence the channel on the following cycle; no note resumes after release until trigger_in.

Configuration
REQ-028 Macro PULSE_ENVELOPE_EN SHALL compile in the decay envelope.
REQ-029 With PULSE_ENVELOPE_EN: trigger loads envelope level from volume_in and clears the divider; when env_period_in!=0, every env_period_in wraps decrement level by 1, saturating at 0 (state stays PLAY); vol_eff = level; env_period_in==0 holds level.
REQ-030 Without PULSE_ENVELOPE_EN: vol_eff = volume_in; env_period_in SHALL be ignored; no envelope registers exist.

Verification (PHASE_W=32, AMP_W=8, phase_incr_in=32'h2000_0000 unless stated)
REQ-031 duty 2, volume 15, length 4, halt 0, trigger then continuous step_in -> amp_out +120 for 4 steps, -120 for 4 steps, repeating; active_out falls after 32nd step, amp_out 0 one cycle later.
REQ-032 duty 0, volume 8 -> per 8-step period amp_out +64 for 1 step, -64 for 7 steps; duty 3 -> +64 for 6, -64 for 2.
REQ-033 trigger and step_in together mid-note, length 2 -> phase 0, no decrement, exactly 16 further steps before IDLE; length_in 0, halt 0 -> active_out stays 0.
REQ-034 length_halt_in 1, length 1 -> still PLAY after 1000 steps; rst_in pulse -> amp_out 0 and active_out 0 next cycle, remain so with steps until retrigger.
REQ-035 PULSE_ENVELOPE_EN defined, volume 3, env_period_in 1, halt 1 -> amplitude +-24, +-16, +-8 over successive periods, then 0 with active_out high; undefined build same stimulus -> constant +-24.

Source files
------------

// File: rtl/pulse_channel_if.sv
// Control and sample bus for the pulse_channel tone generator.
// The master drives note/timbre controls; the slave returns the sample and activity flag.
interface pulse_channel_if #(
    parameter int PHASE_W = 32,
    parameter int AMP_W   = 8,
    parameter int LEN_W   = 8
);
    logic               step_in;
    logic [PHASE_W-1:0] phase_incr_in;
    logic [1:0]         duty_in;
    logic [3:0]         volume_in;
    logic               trigger_in;
    logic [LEN_W-1:0]   length_in;
    logic               length_halt_in;
    logic [3:0]         env_period_in;
    logic [AMP_W-1:0]   amp_out;
    logic               active_out;

    modport master (
        output step_in, phase_incr_in, duty_in, volume_in, trigger_in,
        output length_in, length_halt_in, env_period_in,
        input  amp_out, active_out
    );

    modport slave (
        input  step_in, phase_incr_in, duty_in, volume_in, trigger_in,
        input  length_in, length_halt_in, env_period_in,
        output amp_out, active_out
    );
endinterface

// File: rtl/pulse_channel.sv
// Square-wave pulse channel: phase accumulator, duty shaping, note length counter.
// Define PULSE_ENVELOPE_EN to build in the per-note decay envelope.
module pulse_channel #(
    parameter int PHASE_W = 32,
    parameter int AMP_W   = 8,
    parameter int LEN_W   = 8
) (
    input logic            clk_in,
    input logic            rst_in,
    pulse_channel_if.slave bus
);

    typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [PHASE_W-1:0] phase_r, phase_s;
    logic [PHASE_W:0]   sum_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic               advance_s;
    logic               wrap_s;
    logic               high_s;
    logic [3:0]         vol_eff_s;
    logic [AMP_W-1:0]   mag_s;
    logic [AMP_W-1:0]   amp_r, amp_s;

    function automatic logic duty_high(input logic [2:0] t, input logic [1:0] duty);
        logic h;
        case (duty)
            2'd0:    h = (t < 3'd1);
            2'd1:    h = (t < 3'd2);
            2'd2:    h = (t < 3'd4);
            2'd3:    h = (t < 3'd6);
            default: h = 1'b0;
        endcase
        return h;
    endfunction

    // Next-state logic: trigger restarts the note and always outranks a step.
    always_comb begin
        sum_s     = {1'b0, phase_r} + {1'b0, bus.phase_incr_in};
        advance_s = (state_r == PLAY) && bus.step_in && !bus.trigger_in;
        wrap_s    = advance_s && sum_s[PHASE_W];
        state_s   = state_r;
        phase_s   = phase_r;
        len_s     = len_r;
        if (bus.trigger_in) begin
            phase_s = '0;
            len_s   = bus.length_in;
            if ((bus.length_in == '0) && !bus.length_halt_in) begin
                state_s = IDLE;
            end else begin
                state_s = PLAY;
            end
        end else if (advance_s) begin
            phase_s = sum_s[PHASE_W-1:0];
            // A counter already at zero (halt released mid-note) stays put.
            if (wrap_s && !bus.length_halt_in && (len_r != '0)) begin
                len_s = len_r - LEN_ONE;
                if (len_r == LEN_ONE) begin
                    state_s = IDLE;
                end else begin
                    state_s = PLAY;
                end
            end else begin
                len_s = len_r;
            end
        end else begin
            phase_s = phase_r;
        end
    end

`ifdef PULSE_ENVELOPE_EN
    logic [3:0] env_lvl_r, env_lvl_s;
    logic [3:0] env_div_r, env_div_s;

    // Envelope: one level step down every env_period_in waveform wraps.
    always_comb begin
        env_lvl_s = env_lvl_r;
        env_div_s = env_div_r;
        if (bus.trigger_in) begin
            env_lvl_s = bus.volume_in;
            env_div_s = 4'd0;
        end else if (wrap_s && (bus.env_period_in != 4'd0)) begin
            if (({1'b0, env_div_r} + 5'd1) >= {1'b0, bus.env_period_in}) begin
                env_div_s = 4'd0;
                env_lvl_s = (env_lvl_r != 4'd0) ? (env_lvl_r - 4'd1) : 4'd0;
            end else begin
                env_div_s = env_div_r + 4'd1;
            end
        end else begin
            env_div_s = env_div_r;
        end
    end

    assign vol_eff_s = env_lvl_r;

    // Envelope registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            env_lvl_r <= 4'd0;
            env_div_r <= 4'd0;
        end else begin
            env_lvl_r <= env_lvl_s;
            env_div_r <= env_div_s;
        end
    end
`else
    assign vol_eff_s = bus.volume_in;
`endif

    // Sample shaping from the current phase, so the output lags by one cycle.
    always_comb begin
        high_s = duty_high(phase_r[PHASE_W-1 -: 3], bus.duty_in);
        mag_s  = AMP_W'(vol_eff_s) << (AMP_W - 5);
        if (state_r == PLAY) begin
            amp_s = high_s ? mag_s : -mag_s;
        end else begin
            amp_s = '0;
        end
    end

    // State, phase, length and sample registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            phase_r <= '0;
            len_r   <= '0;
            amp_r   <= '0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            len_r   <= len_s;
            amp_r   <= amp_s;
        end
    end

    assign bus.amp_out    = amp_r;
    assign bus.active_out = (state_r == PLAY);

endmodule

// File: tb/tb_pulse_channel.sv
// Directed and randomized bench for pulse_channel against a note-level reference model.
module tb_pulse_channel;

`ifdef PULSE_ENVELOPE_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif
    localparam longint unsigned FULL = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: note playing flag, phase, periods remaining, envelope.
    bit              m_play = 1'b0;
    longint unsigned m_phase = 0;
    int              m_len = 0;
    int              m_lvl = 0;
    int              m_div = 0;

    pulse_channel_if #(.PHASE_W(32), .AMP_W(8), .LEN_W(8)) bus ();

    pulse_channel #(.PHASE_W(32), .AMP_W(8), .LEN_W(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic int amp_now();
        return int'($signed(bus.amp_out));
    endfunction

    // High while phase is below the duty fraction (1/8, 2/8, 4/8, 6/8) of a full period.
    function automatic bit is_high(longint unsigned ph, int duty);
        longint unsigned eighths;
        case (duty)
            0:       eighths = 1;
            1:       eighths = 2;
            2:       eighths = 4;
            default: eighths = 6;
        endcase
        return ph < (eighths * FULL / 8);
    endfunction

    task automatic chk(string tag, int got, int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: predict, advance the model, then compare after the edge.
    task automatic tick();
        int              ve;
        int              e_amp;
        longint unsigned sum;
        bit              wrap;
        ve = ENV ? m_lvl : int'(bus.volume_in);
        if (rst || !m_play) e_amp = 0;
        else e_amp = is_high(m_phase, int'(bus.duty_in)) ? ve * 8 : -ve * 8;
        if (rst) begin
            m_play = 1'b0; m_phase = 0; m_len = 0; m_lvl = 0; m_div = 0;
        end else if (bus.trigger_in) begin
            m_phase = 0;
            m_len   = int'(bus.length_in);
            m_play  = !(m_len == 0 && !bus.length_halt_in);
            m_lvl   = int'(bus.volume_in);
            m_div   = 0;
        end else if (m_play && bus.step_in) begin
            sum     = m_phase + longint'(bus.phase_incr_in);
            wrap    = sum >= FULL;
            m_phase = sum % FULL;
            if (wrap && !bus.length_halt_in && m_len > 0) begin
                m_len--;
                if (m_len == 0) m_play = 1'b0;
            end
            if (wrap && bus.env_period_in != 4'd0) begin
                m_div++;
                if (m_div >= int'(bus.env_period_in)) begin
                    m_div = 0;
                    if (m_lvl > 0) m_lvl--;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("amp_model", amp_now(), e_amp);
        chk("active_model", int'(bus.active_out), int'(m_play));
    endtask

    task automatic trig(int len, bit halt);
        bus.length_in      = 8'(len);
        bus.length_halt_in = halt;
        bus.trigger_in     = 1'b1;
        bus.step_in        = 1'b0;
        tick();
        bus.trigger_in     = 1'b0;
    endtask

    initial begin
        int exp_amp;
        int mag;
        int cnt;
        rst                = 1'b1;
        bus.step_in        = 1'b0;
        bus.phase_incr_in  = 32'h2000_0000;
        bus.duty_in        = 2'd2;
        bus.volume_in      = 4'd15;
        bus.trigger_in     = 1'b0;
        bus.length_in      = 8'd0;
        bus.length_halt_in = 1'b0;
        bus.env_period_in  = 4'd0;
        tick();
        tick();
        chk("reset_amp", amp_now(), 0);
        chk("reset_active", int'(bus.active_out), 0);
        rst = 1'b0;
        tick();

        // Duty 50%, volume 15, four periods then silence.
        trig(4, 1'b0);
        bus.step_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            exp_amp = ((i % 8) < 4) ? 120 : -120;
            chk("d50_amp", amp_now(), exp_amp);
            chk("d50_active", int'(bus.active_out), (i < 31) ? 1 : 0);
        end
        bus.step_in = 1'b0;
        tick();
        chk("d50_silent", amp_now(), 0);

        // Duty 12.5% then 75% without retrigger, volume 8.
        bus.volume_in = 4'd8;
        bus.duty_in   = 2'd0;
        trig(0, 1'b1);
        bus.step_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) bus.duty_in = 2'd3;
            tick();
            if (i < 8) exp_amp = (i == 0) ? 64 : -64;
            else       exp_amp = ((i % 8) < 6) ? 64 : -64;
            chk("duty_amp", amp_now(), exp_amp);
        end

        // Trigger with step mid-note: phase restarts, full 16 steps remain.
        bus.duty_in = 2'd2;
        trig(2, 1'b0);
        bus.step_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.trigger_in = 1'b1;
        tick();
        bus.trigger_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && bus.active_out === 1'b1; i++) begin
            tick();
            cnt++;
        end
        chk("retrig_steps", cnt, 16);
        trig(0, 1'b0);
        chk("len0_active", int'(bus.active_out), 0);
        bus.step_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("len0_stays", int'(bus.active_out), 0);

        // Halted length keeps playing; reset silences until retrigger.
        trig(1, 1'b1);
        bus.step_in = 1'b1;
        for (int i = 0; i < 1000; i++) tick();
        chk("halt_play", int'(bus.active_out), 1);
        rst = 1'b1;
        tick();
        chk("rst_amp", amp_now(), 0);
        chk("rst_active", int'(bus.active_out), 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("post_rst_active", int'(bus.active_out), 0);
        chk("post_rst_amp", amp_now(), 0);
        trig(1, 1'b0);
        chk("retrig_active", int'(bus.active_out), 1);

        // Envelope decay: volume 3, one level per period.
        bus.volume_in     = 4'd3;
        bus.env_period_in = 4'd1;
        trig(1, 1'b1);
        bus.step_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ENV) mag = ((3 - i / 8) > 0) ? (3 - i / 8) * 8 : 0;
            else     mag = 24;
            exp_amp = ((i % 8) < 4) ? mag : -mag;
            chk("env_amp", amp_now(), exp_amp);
        end
        chk("env_active", int'(bus.active_out), 1);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) begin
                bus.phase_incr_in  = $urandom() >> $urandom_range(1, 5);
                bus.duty_in        = 2'($urandom_range(0, 3));
                bus.volume_in      = 4'($urandom_range(0, 15));
                bus.length_halt_in = ($urandom_range(0, 4) == 0);
                bus.env_period_in  = 4'($urandom_range(0, 3));
            end
            rst            = ($urandom_range(0, 199) == 0);
            bus.trigger_in = ($urandom_range(0, 39) == 0);
            bus.step_in    = ($urandom_range(0, 3) != 0);
            bus.length_in  = 8'($urandom_range(0, 4));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
